// File: rtl/ahbl_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_sram_slave_pkg
// Shared AHB-Lite definitions: data-phase state encoding, HTRANS/HSIZE/HRESP
// constants, and the byte-lane mask function used by the bus multiplexer and
// the SRAM slave.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ahbl_sram_slave_pkg;

    // Data-phase states of the SRAM slave.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_RDATA  = 3'd2;
    localparam logic [2:0] ST_RSTALL = 3'd3;
    localparam logic [2:0] ST_ERR1   = 3'd4;
    localparam logic [2:0] ST_ERR2   = 3'd5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic       err;
        logic [7:0] mask;
    } bytemask_t;

    // Only NONSEQ and SEQ carry a real transfer.
    function automatic logic htrans_active(input logic [1:0] htrans);
        logic act;
        act = 1'b0;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
        endcase
        return act;
    endfunction

    // Lane mask for a 64-bit bus; err flags an oversize or misaligned access.
    function automatic bytemask_t byte_mask(input logic [2:0] size,
                                            input logic [2:0] addr);
        bytemask_t res;
        res.err  = 1'b0;
        res.mask = 8'h00;
        case (size)
            HSIZE_BYTE:  res.mask = 8'h01 << addr;
            HSIZE_HALF: begin
                res.mask = 8'h03 << {addr[2:1], 1'b0};
                res.err  = addr[0];
            end
            HSIZE_WORD: begin
                res.mask = 8'h0F << {addr[2], 2'b00};
                res.err  = |addr[1:0];
            end
            HSIZE_DWORD: begin
                res.mask = 8'hFF;
                res.err  = |addr;
            end
            default:     res.err  = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ahbl_bytemask.sv
// ---------------------------------------------------------------------------
// ahbl_bytemask
// Maps an AHB transfer size and low address bits to the 8-lane write mask and
// an alignment/size error flag.
// Ports:
//   i_size  [2:0]  HSIZE of the transfer
//   i_addr  [2:0]  HADDR[2:0] of the transfer
//   o_mask  [7:0]  active byte lanes
//   o_err          1 = oversize or misaligned transfer
// ---------------------------------------------------------------------------
module ahbl_bytemask
    import ahbl_sram_slave_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [2:0] i_addr,
    output logic [7:0] o_mask,
    output logic       o_err
);

    bytemask_t w_result;

    assign w_result = byte_mask(i_size, i_addr);
    assign o_mask   = w_result.mask;
    assign o_err    = w_result.err;

endmodule

// File: rtl/ahbl_sram_slave.sv
// ---------------------------------------------------------------------------
// ahbl_sram_slave
// Zero-wait AHB-Lite slave in front of a single-port synchronous SRAM.
// Writes complete in their data phase; reads are issued in their address
// phase, except when that phase overlaps a write data phase, in which case
// one stall cycle (RSTALL) is inserted. Bad size/alignment gives a two-cycle
// ERROR response without touching the SRAM.
// Ports:
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   HSEL..HREADY              AHB-Lite slave inputs
//   HREADYOUT, HRESP, HRDATA  AHB-Lite slave outputs
//   sram_*                    SRAM port (read data valid one cycle after a
//                             read strobe)
// ---------------------------------------------------------------------------
module ahbl_sram_slave
    import ahbl_sram_slave_pkg::*;
#(
    parameter int SZ     = 64,
    parameter int MEM_AW = 12
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HADDR,
    input  logic [SZ-1:0]     HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [SZ-1:0]     HRDATA,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [7:0]        sram_wmask,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [SZ-1:0]     sram_wdata,
    input  logic [SZ-1:0]     sram_rdata
);

    logic [2:0]        r_state;
    logic [MEM_AW-1:0] r_addr;
    logic [7:0]        r_mask;   // encodes the registered size as lanes

    logic [2:0]        w_next_state;
    logic              w_ready;
    logic              w_accept;
    logic              w_err;
    logic [7:0]        w_mask;
    logic [MEM_AW-1:0] w_word_addr;
    logic              w_unused_haddr;

    // Upper address bits alias onto the SRAM.
    assign w_word_addr    = HADDR[MEM_AW+2:3];
    assign w_unused_haddr = &{1'b0, HADDR[31:MEM_AW+3]};

    ahbl_bytemask u_bytemask (
        .i_size (HSIZE),
        .i_addr (HADDR[2:0]),
        .o_mask (w_mask),
        .o_err  (w_err)
    );

    assign w_ready   = (r_state != ST_RSTALL) && (r_state != ST_ERR1);
    assign HREADYOUT = w_ready;

    // Gated by HRESETn so an address phase seen during reset cannot strobe
    // the SRAM through the combinational read path.
    assign w_accept = HRESETn & HSEL & HREADY & w_ready & htrans_active(HTRANS);

    // Direction of the data phase is carried by the state itself.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_RSTALL: w_next_state = ST_RDATA;
            ST_ERR1:   w_next_state = ST_ERR2;
            default: begin
                if (w_accept) begin
                    if (w_err)
                        w_next_state = ST_ERR1;
                    else if (HWRITE)
                        w_next_state = ST_WDATA;
                    else if (r_state == ST_WDATA)
                        w_next_state = ST_RSTALL;
                    else
                        w_next_state = ST_RDATA;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_mask  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr <= w_word_addr;
                r_mask <= w_mask;
            end
        end
    end

    // The write data phase owns the SRAM port; a read that arrives during it
    // is deferred to RSTALL and re-issued from the registered address, which
    // also guarantees it sees the word just written.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = r_addr;
        sram_wdata = '0;
        if (r_state == ST_WDATA) begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_wmask = r_mask;
            sram_wdata = HWDATA;
        end else if (r_state == ST_RSTALL) begin
            sram_cs    = 1'b1;
        end else if (w_accept && !w_err && !HWRITE) begin
            sram_cs    = 1'b1;
            sram_addr  = w_word_addr;
        end
    end

    assign HRDATA = (r_state == ST_RDATA) ? sram_rdata : '0;
    assign HRESP  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ?
                    HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahbl_sram_slave
// Directed bench for ahbl_sram_slave with a behavioural synchronous SRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after it.
// ---------------------------------------------------------------------------
module tb_ahbl_sram_slave;
    import ahbl_sram_slave_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;
    logic        sram_cs;
    logic        sram_we;
    logic [7:0]  sram_wmask;
    logic [11:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata = '0;
    logic        other_busy;

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    logic [63:0] mem [0:4095];

    always #5 HCLK = ~HCLK;

    // Single slave on the bus unless another slave is modelled as stalling.
    assign HREADY = HREADYOUT & ~other_busy;

    ahbl_sram_slave dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HADDR      (HADDR),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always @(posedge HCLK) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
    endtask

    task automatic idle();
        drive(1'b1, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    endtask

    initial begin
        HRESETn    = 1'b0;
        other_busy = 1'b0;
        HWDATA     = '0;
        idle();

        // Reset values
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_hreadyout", HREADYOUT, 1);
        check("rst_hresp", HRESP, 0);
        check("rst_hrdata", HRDATA, 0);
        check("rst_cs", sram_cs, 0);
        check("rst_we", sram_we, 0);
        check("rst_wmask", sram_wmask, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Doubleword write then read of 0x10, no wait states
        next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_DWORD, 32'h10); #1;
        check("wr_aphase_cs", sram_cs, 0);
        next_cycle(); idle(); HWDATA = 64'h1122334455667788; #1;
        check("wr_cs", sram_cs, 1);
        check("wr_we", sram_we, 1);
        check("wr_wmask", sram_wmask, 8'hFF);
        check("wr_addr", sram_addr, 12'd2);
        check("wr_wdata", sram_wdata, 64'h1122334455667788);
        check("wr_hreadyout", HREADYOUT, 1);
        next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 32'h10); HWDATA = '0; #1;
        check("rd_aphase_cs", sram_cs, 1);
        check("rd_aphase_we", sram_we, 0);
        check("rd_aphase_addr", sram_addr, 12'd2);
        next_cycle(); idle(); #1;
        check("rd_hreadyout", HREADYOUT, 1);
        check("rd_hrdata", HRDATA, 64'h1122334455667788);
        check("rd_hresp", HRESP, 0);

        // Byte write 0xAB to 0x13 over a zeroed doubleword
        next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_DWORD, 32'h10);
        next_cycle(); idle(); HWDATA = '0;
        next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h13);
        next_cycle(); idle(); HWDATA = 64'hABABABABABABABAB; #1;
        check("bw_wmask", sram_wmask, 8'h08);
        check("bw_addr", sram_addr, 12'd2);
        next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 32'h10); HWDATA = '0;
        next_cycle(); idle(); #1;
        check("bw_readback", HRDATA, 64'h00000000AB000000);

        // Write 0x20 immediately followed by read 0x20: one stall cycle
        next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_DWORD, 32'h20);
        next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 32'h20);
        HWDATA = 64'hCAFEF00DDEADBEEF; #1;
        check("b2b_wr_hreadyout", HREADYOUT, 1);
        check("b2b_wr_we", sram_we, 1);
        check("b2b_wr_addr", sram_addr, 12'd4);
        next_cycle(); idle(); HWDATA = '0; #1;
        check("b2b_stall_hreadyout", HREADYOUT, 0);
        check("b2b_stall_cs", sram_cs, 1);
        check("b2b_stall_we", sram_we, 0);
        check("b2b_stall_addr", sram_addr, 12'd4);
        next_cycle(); #1;
        check("b2b_rd_hreadyout", HREADYOUT, 1);
        check("b2b_rd_hrdata", HRDATA, 64'hCAFEF00DDEADBEEF);
        next_cycle(); #1;
        check("b2b_idle_hrdata", HRDATA, 0);

        // Misaligned halfword, then HSIZE=4 accepted in ERR2
        next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_HALF, 32'h01); #1;
        check("mis_aphase_cs", sram_cs, 0);
        next_cycle(); idle(); #1;
        check("mis_err1_hreadyout", HREADYOUT, 0);
        check("mis_err1_hresp", HRESP, 1);
        check("mis_err1_cs", sram_cs, 0);
        next_cycle(); drive(1, HTRANS_NONSEQ, 0, 3'd4, 32'h08); #1;
        check("mis_err2_hreadyout", HREADYOUT, 1);
        check("mis_err2_hresp", HRESP, 1);
        check("sz4_aphase_cs", sram_cs, 0);
        next_cycle(); idle(); #1;
        check("sz4_err1_hreadyout", HREADYOUT, 0);
        check("sz4_err1_hresp", HRESP, 1);
        check("sz4_err1_cs", sram_cs, 0);
        next_cycle(); #1;
        check("sz4_err2_hreadyout", HREADYOUT, 1);
        check("sz4_err2_hresp", HRESP, 1);
        next_cycle(); #1;
        check("err_done_hresp", HRESP, 0);
        check("err_done_hreadyout", HREADYOUT, 1);

        // Transfers that must be ignored
        next_cycle(); drive(0, HTRANS_NONSEQ, 0, HSIZE_DWORD, 32'h10); #1;
        check("nosel_cs", sram_cs, 0);
        check("nosel_hreadyout", HREADYOUT, 1);
        next_cycle(); drive(1, HTRANS_BUSY, 0, HSIZE_DWORD, 32'h10); #1;
        check("busy_cs", sram_cs, 0);
        check("nosel_no_rdata", HRDATA, 0);
        next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 32'h10); other_busy = 1'b1; #1;
        check("hready0_cs", sram_cs, 0);
        next_cycle(); idle(); other_busy = 1'b0; #1;
        check("ignored_cs", sram_cs, 0);
        check("ignored_hreadyout", HREADYOUT, 1);
        check("ignored_hrdata", HRDATA, 0);

        // Reset pulse during RSTALL, then a normal read
        next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_DWORD, 32'h28);
        next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 32'h28);
        HWDATA = 64'h0F1E2D3C4B5A6978;
        next_cycle(); idle(); HWDATA = '0; #1;
        check("prerst_stall", HREADYOUT, 0);
        #1; HRESETn = 1'b0; #1;
        check("midrst_hreadyout", HREADYOUT, 1);
        check("midrst_hresp", HRESP, 0);
        check("midrst_hrdata", HRDATA, 0);
        check("midrst_cs", sram_cs, 0);
        check("midrst_we", sram_we, 0);
        check("midrst_wmask", sram_wmask, 0);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        next_cycle(); #1;
        check("postrst_cs", sram_cs, 0);
        next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_DWORD, 32'h28); #1;
        check("postrst_rd_cs", sram_cs, 1);
        check("postrst_rd_addr", sram_addr, 12'd5);
        next_cycle(); idle(); #1;
        check("postrst_rd_hrdata", HRDATA, 64'h0F1E2D3C4B5A6978);
        check("postrst_rd_hreadyout", HREADYOUT, 1);
        check("postrst_rd_hresp", HRESP, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahbl_sram_slave.md
AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Interface
REQ-001 SHALL have parameter SZ, default 64, meaning data bus width in bits (fixed 64; 8 byte lanes).
REQ-002 SHALL have parameter MEM_AW, default 12, meaning SRAM word-address width (2^MEM_AW 64-bit words).
REQ-003 SHALL have port HCLK  input  1  system clock; the block SHALL use one clock only.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports HSEL, HTRANS[1:0], HWRITE, HSIZE[2:0], HADDR[31:0], HWDATA[SZ-1:0], HREADY: AHB-Lite slave-side inputs.
REQ-006 SHALL have outputs HREADYOUT (1), HRESP (1; 0=OKAY, 1=ERROR) and HRDATA[SZ-1:0].
REQ-007 SHALL have SRAM outputs sram_cs (1), sram_we (1), sram_wmask[7:0], sram_addr[MEM_AW-1:0] and sram_wdata[SZ-1:0], plus input sram_rdata[SZ-1:0]; the SRAM is single-port, synchronous, with read data valid the cycle after sram_cs with sram_we=0.

Function
REQ-008 SHALL accept a transfer only when HSEL & HTRANS[1] & HREADY; IDLE/BUSY or unselected cycles SHALL be ignored.
REQ-009 SHALL register the accepted address, size, and direction for the data phase; the word address SHALL be HADDR[MEM_AW+2:3], and upper bits SHALL be ignored (aliasing).
REQ-010 SHALL set the byte mask as follows: HSIZE=0 gives 1 lane at HADDR[2:0]; 1 gives 2 lanes at HADDR[2:1]; 2 gives 4 lanes at HADDR[2]; 3 gives all 8 lanes.
REQ-011 SHALL treat HSIZE>3, or an address not aligned to its size, as an error transfer with no SRAM access.
REQ-012 SHALL implement states IDLE, WDATA, RDATA, RSTALL, ERR1 and ERR2.
REQ-013 SHALL complete writes with zero wait: in WDATA, drive sram_cs=1, sram_we=1, the registered address, and mask with sram_wdata=HWDATA, and HREADYOUT=1.
REQ-014 SHALL issue a read accepted outside WDATA to the SRAM in its address-phase cycle (sram_cs=1, sram_we=0, address from HADDR); the next cycle SHALL be RDATA with HREADYOUT=1 and HRDATA=sram_rdata.
REQ-015 SHALL handle a read accepted during WDATA (port conflict) as follows: enter RSTALL with HREADYOUT=0 and issue the read from the registered address, then RDATA with HREADYOUT=1.
REQ-016 SHALL return the newly written data on a read in RSTALL after a write to the same word (the SRAM is written before the read is issued).
REQ-017 SHALL give an error response as ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), and then return to IDLE unless a new transfer is accepted in ERR2.
REQ-018 SHALL drive HRDATA as 0 outside RDATA; HRESP SHALL be 0 outside ERR1/ERR2.
REQ-019 SHALL support back-to-back pipelined transfers: a transfer accepted in any state with HREADYOUT=1 SHALL set the next state directly, with no idle cycle inserted.
REQ-020 SHALL hold sram_cs=0 whenever no access is defined by REQ-013 to REQ-015.

Reset
REQ-021 SHALL, on HRESETn=0, immediately (asynchronously) set: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, sram_cs=0, sram_we=0, sram_wmask=0, and all registered address-phase fields to 0.
REQ-022 SHALL abandon any transfer in progress when reset is asserted mid-transfer; no SRAM write SHALL occur in the cycle reset deasserts.

Structure
REQ-023 SHALL take the state encoding, HTRANS/HSIZE/HRESP constants, and the byte-mask function from the shared AHB-Lite package used by the bus multiplexer.
REQ-024 SHALL contain one sub-module, ahbl_bytemask, that maps HSIZE and HADDR[2:0] to the mask and an alignment-error flag; the rest is flat.

Verification
REQ-025 SHALL be tested with: write doubleword 0x1122334455667788 to 0x10, then read 0x10 -> read has 0 wait states, HRDATA=0x1122334455667788, HRESP=0.
REQ-026 SHALL be tested with: byte write 0xAB to 0x13 after a doubleword 0 was written to 0x10, then read 0x10 -> sram_wmask=0x08, read returns 0x00000000AB000000.
REQ-027 SHALL be tested with: back-to-back write 0x20 then read 0x20 -> exactly one HREADYOUT=0 cycle (RSTALL), and the read returns the written value.
REQ-028 SHALL be tested with: halfword access to 0x01 (misaligned), then HSIZE=4 -> each gives two-cycle ERROR (HREADYOUT 0 then 1) and sram_cs stays 0.
REQ-029 SHALL be tested with: HSEL=0, or HREADY=0 from another slave, or HTRANS=BUSY -> no SRAM access, HREADYOUT=1.
REQ-030 SHALL be tested with: HRESETn pulsed low during RSTALL -> outputs take REQ-021 values within the same cycle, and the next transfer completes normally.
